// File: rtl/sa_pe_sequencer_pkg.sv
// Shared FSM state type and encodings for the PE-array sequencer.
package sa_pe_sequencer_pkg;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_LOAD_ENC   = 3'd1;
  localparam logic [2:0] ST_LATCH_ENC  = 3'd2;
  localparam logic [2:0] ST_STREAM_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE_ENC,
    S_LOAD   = ST_LOAD_ENC,
    S_LATCH  = ST_LATCH_ENC,
    S_STREAM = ST_STREAM_ENC,
    S_DONE   = ST_DONE_ENC
  } sa_state_e;

endpackage

// File: rtl/sa_seq_counter.sv
// Loadable down-counter with hold; saturates at zero. Load wins over hold, 1-cycle update latency.
module sa_seq_counter #(
  parameter int W = 8
) (
  input  logic         en_clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_hold,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge en_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sa_pe_sequencer.sv
// PE-array job sequencer (LOAD/LATCH/STREAM/DONE); registered outputs appear the cycle after start.
// Define SA_SEQ_STALL_EN to let stall insert bubble cycles; otherwise stall is ignored.
module sa_pe_sequencer
  import sa_pe_sequencer_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int LEN_BW = 8
) (
  input  logic              en_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_BW-1:0] cfg_len,
  input  logic              stall,
  output logic              pe_en,
  output logic              str_en,
  output logic              mul_en,
  output logic              w_req,
  output logic              f_req,
  output logic              res_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = LEN_BW + $clog2(COLS) + 1;
  localparam logic [CW-1:0] ROWS_M1 = CW'(ROWS - 1);
  localparam logic [CW-1:0] COLS_M1 = CW'(COLS - 1);

  sa_state_e         r_state;
  logic [LEN_BW-1:0] r_len;
  logic              r_frozen;
  logic              r_pe_en, r_str_en, r_mul_en, r_w_req, r_f_req;
  logic              r_res_valid, r_busy, r_done, r_err;

  logic              w_stall, w_freeze, w_accept;
  logic              w_cnt_load, w_cnt_hold, w_cnt_zero;
  logic [CW-1:0]     w_cnt_val, w_cnt;

`ifdef SA_SEQ_STALL_EN
  assign w_stall = stall;
`else
  logic w_unused_stall;
  assign w_unused_stall = stall;
  assign w_stall        = 1'b0;
`endif

  assign w_freeze = w_stall &&
                    (r_state == S_LOAD || r_state == S_LATCH || r_state == S_STREAM);
  assign w_accept = (r_state == S_IDLE) && start && (cfg_len != '0);

  // One counter times both phases: ROWS-1 on accept, len+COLS-2 when leaving LATCH.
  assign w_cnt_load = w_accept || (r_state == S_LATCH && !w_freeze);
  assign w_cnt_val  = w_accept ? ROWS_M1 : (CW'(r_len) + COLS_M1 - CW'(1));
  assign w_cnt_hold = w_freeze || !(r_state == S_LOAD || r_state == S_STREAM);

  sa_seq_counter #(.W(CW)) u_cnt (
    .en_clk     (en_clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_hold     (w_cnt_hold),
    .i_load_val (w_cnt_val),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge en_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_frozen    <= 1'b0;
      r_pe_en     <= 1'b0;
      r_str_en    <= 1'b0;
      r_mul_en    <= 1'b0;
      r_w_req     <= 1'b0;
      r_f_req     <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_pe_en     <= 1'b0;
      r_str_en    <= 1'b0;
      r_w_req     <= 1'b0;
      r_f_req     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_frozen    <= 1'b0;
      r_res_valid <= (r_state == S_STREAM) && !r_frozen;
      // A frozen cycle is a bubble: state, mul_en and busy keep their values.
      if (w_freeze) begin
        r_frozen <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_mul_en <= 1'b0;
            if (start) begin
              if (cfg_len != '0) begin
                r_len   <= cfg_len;
                r_state <= S_LOAD;
                r_pe_en <= 1'b1;
                r_w_req <= 1'b1;
                r_busy  <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            r_pe_en <= 1'b1;
            if (w_cnt_zero) begin
              r_state  <= S_LATCH;
              r_str_en <= 1'b1;
            end else begin
              r_w_req <= 1'b1;
            end
          end
          S_LATCH: begin
            r_state  <= S_STREAM;
            r_pe_en  <= 1'b1;
            r_mul_en <= 1'b1;
            r_f_req  <= 1'b1;
          end
          S_STREAM: begin
            if (w_cnt_zero) begin
              r_state  <= S_DONE;
              r_mul_en <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_pe_en <= 1'b1;
              r_f_req <= (w_cnt > COLS_M1);
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_mul_en <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pe_en     = r_pe_en;
  assign str_en    = r_str_en;
  assign mul_en    = r_mul_en;
  assign w_req     = r_w_req;
  assign f_req     = r_f_req;
  assign res_valid = r_res_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_sa_pe_sequencer.sv
// Directed and random checks of sa_pe_sequencer against a job-timeline reference model.
module tb_sa_pe_sequencer;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int LEN_BW = 8;

  logic en_clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic [LEN_BW-1:0] cfg_len = '0;
  logic pe_en, str_en, mul_en, w_req, f_req, res_valid, busy, done, err;

  int checks = 0;
  int errors = 0;

  // Reference model: job position m_p counts executed steps of the job timeline.
  bit m_busy = 0, m_bub = 0, m_rv = 0, m_err = 0;
  int m_p = 0, m_len = 0;
  logic [8:0] obs;

  always #5 en_clk = ~en_clk;

  sa_pe_sequencer #(.ROWS(ROWS), .COLS(COLS), .LEN_BW(LEN_BW)) dut (
    .en_clk(en_clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .stall(stall),
    .pe_en(pe_en), .str_en(str_en), .mul_en(mul_en), .w_req(w_req), .f_req(f_req),
    .res_valid(res_valid), .busy(busy), .done(done), .err(err)
  );

  // 0 = weight load, 1 = latch, 2 = stream, 3 = done
  function automatic int kind(int p, int len);
    if (p < ROWS) return 0;
    if (p == ROWS) return 1;
    if (p <= ROWS + len + COLS - 1) return 2;
    return 3;
  endfunction

  function automatic logic [8:0] model_out();
    int k;
    bit act;
    logic [8:0] v;
    k = kind(m_p, m_len);
    act = m_busy && !m_bub;
    v[8] = act && (k <= 2);
    v[7] = act && (k == 1);
    v[6] = m_busy && (k == 2);
    v[5] = act && (k == 0);
    v[4] = act && (k == 2) && ((m_p - ROWS - 1) < m_len);
    v[3] = m_rv;
    v[2] = m_busy;
    v[1] = m_busy && (k == 3);
    v[0] = m_err;
    return v;
  endfunction

  task automatic model_step(input bit st, input int len, input bit stl);
    bit stall_on;
    int k;
`ifdef SA_SEQ_STALL_EN
    stall_on = stl;
`else
    stall_on = 1'b0 & stl;
`endif
    k = kind(m_p, m_len);
    m_err = 0;
    m_rv = m_busy && (k == 2) && !m_bub;
    if (!m_busy) begin
      if (st) begin
        if (len != 0) begin
          m_busy = 1; m_p = 0; m_bub = 0; m_len = len;
        end else begin
          m_err = 1;
        end
      end
    end else if (k == 3) begin
      m_busy = 0; m_bub = 0;
    end else if (stall_on) begin
      m_bub = 1;
    end else begin
      m_p++; m_bub = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: inputs held through the edge, outputs compared 1 time unit after it.
  task automatic cyc(input bit st, input int len, input bit stl);
    start = st;
    cfg_len = LEN_BW'(len);
    stall = stl;
    @(posedge en_clk);
    model_step(st, len, stl);
    #1;
    obs = {pe_en, str_en, mul_en, w_req, f_req, res_valid, busy, done, err};
    chk("model", 32'(obs), 32'(model_out()));
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_busy = 0; m_bub = 0; m_rv = 0; m_err = 0; m_p = 0;
    #1;
    obs = {pe_en, str_en, mul_en, w_req, f_req, res_valid, busy, done, err};
    chk("reset_outputs", 32'(obs), 32'(0));
    @(posedge en_clk);
    @(posedge en_clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Nominal ROWS=COLS=4, cfg_len=3 job with absolute cycle expectations; extra_c re-pulses start.
  task automatic nominal_run(input string tag, input int extra_c);
    int n_done;
    int t;
    logic [5:0] exp;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      cyc((c == 0) || (c == extra_c), 3, 0);
      t = c + 1;
      exp = {(t >= 1 && t <= 4), (t == 5), (t >= 6 && t <= 8), (t >= 6 && t <= 11),
             (t >= 7 && t <= 12), (t == 12)};
      chk(tag, 32'({w_req, str_en, f_req, mul_en, res_valid, done}), 32'(exp));
      if (done) n_done++;
    end
    chk({tag, "_done_count"}, 32'(n_done), 32'(1));
  endtask

  initial begin
    int n_f, n_m, n_d, done_at;
    bit pe_a, pe_b;

    #2;
    obs = {pe_en, str_en, mul_en, w_req, f_req, res_valid, busy, done, err};
    chk("reset_state", 32'(obs), 32'(0));
    @(posedge en_clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0);

    nominal_run("nominal", -1);

    cyc(1, 0, 0);
    chk("zero_len_err", 32'(err), 32'(1));
    chk("zero_len_busy", 32'(busy), 32'(0));
    cyc(0, 0, 0);
    chk("zero_len_err_clear", 32'(err), 32'(0));
    chk("zero_len_busy_after", 32'(busy), 32'(0));

    nominal_run("start_busy", 3);

    done_at = -1; pe_a = 1'b0; pe_b = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cyc(c == 0, 3, (c == 7) || (c == 8));
      if (c == 7) pe_a = pe_en;
      if (c == 8) pe_b = pe_en;
      if (done && done_at < 0) done_at = c + 1;
    end
`ifdef SA_SEQ_STALL_EN
    chk("stall_pe_en", 32'({pe_a, pe_b}), 32'(0));
    chk("stall_done_cycle", 32'(done_at), 32'(14));
`else
    chk("stall_pe_en", 32'({pe_a, pe_b}), 32'(3));
    chk("stall_done_cycle", 32'(done_at), 32'(12));
`endif

    for (int c = 0; c < 8; c++) cyc(c == 0, 3, 0);
    chk("pre_reset_stream", 32'(mul_en), 32'(1));
    do_reset();
    n_d = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(0, 0, 0);
      if (done) n_d++;
    end
    chk("no_done_after_reset", 32'(n_d), 32'(0));
    nominal_run("post_reset", -1);

    n_f = 0; n_m = 0; n_d = 0;
    for (int c = 0; c < 300; c++) begin
      cyc(c == 0, 255, 0);
      if (f_req) n_f++;
      if (mul_en) n_m++;
      if (done) n_d++;
    end
    chk("max_len_f_req", 32'(n_f), 32'(255));
    chk("max_len_stream", 32'(n_m), 32'(258));
    chk("max_len_done", 32'(n_d), 32'(1));

    for (int c = 0; c < 600; c++) begin
      cyc($urandom_range(0, 7) == 0, int'($urandom_range(0, 6)), $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sa_pe_sequencer.md
SA_PE_SEQUENCER -- requirements
Module: sa_pe_sequencer

Interface
- REQ-001 SHALL have parameter ROWS, default 4: PE rows, which is also the weight-shift depth.
- REQ-002 SHALL have parameter COLS, default 4: PE columns, which is also the fmap flush depth.
- REQ-003 SHALL have parameter LEN_BW, default 8: width of cfg_len.
- REQ-004 SHALL have port en_clk, input, 1 bit: clock.
- REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 SHALL have port start, input, 1 bit: single-cycle job request.
- REQ-007 SHALL have port cfg_len, input, LEN_BW bits: fmap vectors per job, sampled on an accepted start.
- REQ-008 SHALL have port stall, input, 1 bit: freezes the sequence (see Configuration).
- REQ-009 SHALL have port pe_en, output, 1 bit: array-wide PE clock-gate enable.
- REQ-010 SHALL have port str_en, output, 1 bit: weight-latch strobe.
- REQ-011 SHALL have port mul_en, output, 1 bit: multiplier weight select.
- REQ-012 SHALL have port w_req, output, 1 bit: source presents one weight row this cycle.
- REQ-013 SHALL have port f_req, output, 1 bit: source presents one fmap vector this cycle.
- REQ-014 SHALL have port res_valid, output, 1 bit: PE products valid.
- REQ-015 SHALL have port busy, output, 1 bit: job in progress.
- REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.
- REQ-017 SHALL have port err, output, 1 bit: one-cycle rejected-start pulse.

Function
- REQ-018 SHALL implement an FSM with states IDLE, LOAD, LATCH, STREAM, DONE.
- REQ-019 IDLE: start=1 with cfg_len!=0 SHALL capture cfg_len and go to LOAD; start=1 with cfg_len==0 SHALL pulse err the next cycle and remain in IDLE.
- REQ-020 LOAD SHALL last exactly ROWS cycles with pe_en=1, w_req=1, mul_en=0, str_en=0, then go to LATCH.
- REQ-021 LATCH SHALL last exactly 1 cycle with pe_en=1, str_en=1, w_req=0, then go to STREAM.
- REQ-022 STREAM SHALL last exactly cfg_len+COLS-1 cycles with pe_en=1 and mul_en=1; f_req=1 only during the first cfg_len of those cycles; then go to DONE.
- REQ-023 res_valid SHALL equal the state==STREAM&&!frozen of the previous cycle, i.e. it is delayed by 1 cycle.
- REQ-024 DONE SHALL last 1 cycle with done=1 and all enables 0, then go to IDLE.
- REQ-025 busy SHALL be 1 in LOAD, LATCH, STREAM and DONE.
- REQ-026 start while busy SHALL be ignored, with no err pulse.
- REQ-027 The stream counter SHALL be LEN_BW+$clog2(COLS)+1 bits wide, so cfg_len=2^LEN_BW-1 does not wrap.
- REQ-028 Outputs SHALL be registered; the first LOAD cycle outputs SHALL appear in the cycle after start is sampled.

Reset
- REQ-029 rst_n low SHALL asynchronously force IDLE, zero all counters, and drive pe_en, str_en, mul_en, w_req, f_req, res_valid, busy, done and err to 0.
- REQ-030 Reset mid-job SHALL abandon the job; after release no done pulse SHALL be issued for it.

Configuration
- REQ-031 With SA_SEQ_STALL_EN defined, stall=1 in LOAD, LATCH or STREAM SHALL hold state and counters, force pe_en, w_req, f_req and str_en to 0 that cycle, and keep mul_en at its current value.
- REQ-032 With SA_SEQ_STALL_EN defined, stall SHALL have no effect in IDLE or DONE.
- REQ-033 Without SA_SEQ_STALL_EN, the stall port SHALL exist but be ignored.

Structure
- REQ-034 A shared package SHALL hold the FSM state enum (3-bit) and the state encoding constants.
- REQ-035 One sub-module, sa_seq_counter (loadable down-counter with hold input and zero flag), SHALL be instantiated and reused for the LOAD and STREAM phases.

Verification
- REQ-036 The bench SHALL cover a nominal job: ROWS=COLS=4, cfg_len=3, start at cycle 0 -> w_req cycles 1-4, str_en cycle 5, f_req cycles 6-8, mul_en cycles 6-11, res_valid cycles 7-12, done cycle 12.
- REQ-037 The bench SHALL cover a zero-length job: cfg_len=0 with start -> err=1 one cycle, busy stays 0.
- REQ-038 The bench SHALL cover start while busy: start pulsed at cycle 3 of the nominal job -> identical timing, exactly one done.
- REQ-039 The bench SHALL cover a stall: with SA_SEQ_STALL_EN, stall=1 for 2 cycles inside STREAM -> pe_en=0 in those cycles and done delayed by exactly 2 cycles.
- REQ-040 The bench SHALL cover reset mid-operation: rst_n low during STREAM -> all outputs 0 immediately, no done after release, and a new start runs the nominal timing.
- REQ-041 The bench SHALL cover maximum length: cfg_len=255 -> f_req high exactly 255 cycles, STREAM exactly 258 cycles.
